// File: rtl/apb_reg_ctrl_if.sv
// APB bus bundle between a master and the apb_reg_ctrl register slave.
interface apb_reg_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_ctrl.sv
// APB slave front-end for NUM_REGS 32-bit registers: one-hot write strobes plus read-back mux.
// Define APB_REG_CTRL_PSLVERR_EN to answer unmapped/misaligned addresses with pslverr.
module apb_reg_ctrl #(
    parameter int NUM_REGS    = 4,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    pclk,
    input  logic                    rst,
    apb_reg_ctrl_if.slave           apb,
    output logic [NUM_REGS-1:0]     wr_en,
    output logic [31:0]             wr_data,
    input  logic [NUM_REGS*32-1:0]  reg_rdata
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_p0;
    logic                write_p0;
    logic [31:0]         wdata_p0;
    logic                pready_q;
    logic [NUM_REGS-1:0] wr_en_q;
    logic [31:0]         rdata_sel;

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[ADDR_W-1:2]} < NUM_REGS_A);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] word;
        word = a >> 2;
        return word[IDX_W-1:0];
    endfunction

    function automatic logic [NUM_REGS-1:0] wr_strobe(input logic [ADDR_W-1:0] a,
                                                      input logic          wr);
        logic [NUM_REGS-1:0] s;
        s = '0;
        if (wr && addr_hit(a)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                s[i] = (addr_idx(a) == IDX_W'(i));
            end
        end
        return s;
    endfunction

    // pready_q and wr_en_q are set on the edge that makes cnt reach zero in ACCESS,
    // so they always equal (state == ACCESS && cnt == 0) without any input decoding.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_p0  <= '0;
            write_p0 <= 1'b0;
            wdata_p0 <= '0;
            pready_q <= 1'b0;
            wr_en_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        addr_p0  <= apb.paddr;
                        write_p0 <= apb.pwrite;
                        wdata_p0 <= apb.pwdata;
                        cnt      <= 4'(WAIT_CYCLES);
                        state    <= ACCESS;
                        pready_q <= (WAIT_CYCLES == 0);
                        wr_en_q  <= (WAIT_CYCLES == 0) ? wr_strobe(apb.paddr, apb.pwrite) : '0;
                    end
                end
                ACCESS: begin
                    if (!apb.psel) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        pready_q <= 1'b0;
                        wr_en_q  <= '0;
                    end else if (cnt != 4'd0) begin
                        cnt      <= cnt - 4'd1;
                        pready_q <= (cnt == 4'd1);
                        wr_en_q  <= (cnt == 4'd1) ? wr_strobe(addr_p0, write_p0) : '0;
                    end else if (apb.penable) begin
                        state    <= IDLE;
                        pready_q <= 1'b0;
                        wr_en_q  <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    pready_q <= 1'b0;
                    wr_en_q  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_idx(addr_p0) == IDX_W'(i)) begin
                rdata_sel = reg_rdata[i*32 +: 32];
            end
        end
    end

    assign apb.prdata = (pready_q && !write_p0 && addr_hit(addr_p0)) ? rdata_sel : '0;
    assign apb.pready = pready_q;
    assign wr_en      = wr_en_q;
    assign wr_data    = wdata_p0;

`ifdef APB_REG_CTRL_PSLVERR_EN
    assign apb.pslverr = pready_q && !addr_hit(addr_p0);
`else
    assign apb.pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_ctrl.sv
// Bench for apb_reg_ctrl: two instances (WAIT_CYCLES 0 and 1) with attached registers,
// directed cases followed by random transfers compared against a transfer-level model.
`timescale 1ns/1ps
module tb_apb_reg_ctrl;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 8;
`ifdef APB_REG_CTRL_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic pclk = 1'b0;
    logic rst;
    always #5 pclk = ~pclk;

    apb_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus0 ();
    apb_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();

    logic [NUM_REGS-1:0]    wr_en0, wr_en1;
    logic [31:0]            wr_data0, wr_data1;
    logic [NUM_REGS*32-1:0] reg_rdata0, reg_rdata1;
    logic [31:0]            regs0 [NUM_REGS];
    logic [31:0]            regs1 [NUM_REGS];

    apb_reg_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .rst(rst), .apb(bus0),
        .wr_en(wr_en0), .wr_data(wr_data0), .reg_rdata(reg_rdata0)
    );

    apb_reg_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut1 (
        .pclk(pclk), .rst(rst), .apb(bus1),
        .wr_en(wr_en1), .wr_data(wr_data1), .reg_rdata(reg_rdata1)
    );

    // Register instances hanging off each controller.
    always_ff @(posedge pclk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs0[i] <= 32'h1000_0000 + 32'(i);
                regs1[i] <= 32'h1000_0100 + 32'(i);
            end else begin
                if (wr_en0[i]) regs0[i] <= wr_data0;
                if (wr_en1[i]) regs1[i] <= wr_data1;
            end
        end
    end

    always_comb begin
        reg_rdata0 = '0;
        reg_rdata1 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_rdata0[i*32 +: 32] = regs0[i];
            reg_rdata1[i*32 +: 32] = regs1[i];
        end
    end

    typedef struct {
        logic                pready;
        logic                pslverr;
        logic [31:0]         prdata;
        logic [31:0]         wr_data;
        logic [NUM_REGS-1:0] wr_en;
    } obs_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [2][NUM_REGS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample(input int w);
        obs_t o;
        if (w == 0) begin
            o.pready = bus0.pready; o.pslverr = bus0.pslverr; o.prdata = bus0.prdata;
            o.wr_data = wr_data0;   o.wr_en = wr_en0;
        end else begin
            o.pready = bus1.pready; o.pslverr = bus1.pslverr; o.prdata = bus1.prdata;
            o.wr_data = wr_data1;   o.wr_en = wr_en1;
        end
        return o;
    endfunction

    task automatic drive(input int w, input logic s, input logic e, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
        if (w == 0) begin
            bus0.psel = s; bus0.penable = e; bus0.pwrite = wr; bus0.paddr = a; bus0.pwdata = d;
        end else begin
            bus1.psel = s; bus1.penable = e; bus1.pwrite = wr; bus1.paddr = a; bus1.pwdata = d;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            mem[0][i] = 32'h1000_0000 + 32'(i);
            mem[1][i] = 32'h1000_0100 + 32'(i);
        end
    endtask

    task automatic chk_all_zero(input int w, input string tag);
        obs_t o;
        o = sample(w);
        chk({tag, "_pready"},  32'(o.pready),  32'd0);
        chk({tag, "_pslverr"}, 32'(o.pslverr), 32'd0);
        chk({tag, "_wr_en"},   32'(o.wr_en),   32'd0);
        chk({tag, "_wr_data"}, o.wr_data,      32'd0);
        chk({tag, "_prdata"},  o.prdata,       32'd0);
    endtask

    // One complete transfer on instance w; instance w has exactly w wait states.
    task automatic xfer(input int w, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d);
        obs_t                o;
        int                  ai, idx, waits;
        logic                hit;
        logic [NUM_REGS-1:0] exp_en;
        logic [31:0]         exp_rd;
        ai     = int'(a);
        hit    = (ai % 4 == 0) && (ai / 4 < NUM_REGS);
        idx    = ai / 4;
        exp_en = '0;
        exp_rd = '0;
        if (hit && wr)  exp_en[idx] = 1'b1;
        if (hit && !wr) exp_rd = mem[w][idx];

        @(negedge pclk);
        o = sample(w);
        chk("pre_pready", 32'(o.pready), 32'd0);
        chk("pre_wr_en",  32'(o.wr_en),  32'd0);
        drive(w, 1'b1, 1'b0, wr, a, d);

        @(negedge pclk);
        drive(w, 1'b1, 1'b1, wr, ADDR_W'($urandom), $urandom);
        waits = 0;
        o = sample(w);
        while (!o.pready && waits < 20) begin
            chk("wait_wr_en",   32'(o.wr_en),   32'd0);
            chk("wait_prdata",  o.prdata,       32'd0);
            chk("wait_pslverr", 32'(o.pslverr), 32'd0);
            chk("wait_wr_data", o.wr_data,      d);
            @(negedge pclk);
            waits++;
            o = sample(w);
        end
        chk("pready",      32'(o.pready),  32'd1);
        chk("wait_states", 32'(waits),     32'(w));
        chk("wr_en",       32'(o.wr_en),   32'(exp_en));
        chk("wr_data",     o.wr_data,      d);
        chk("prdata",      o.prdata,       exp_rd);
        chk("pslverr",     32'(o.pslverr), 32'(ERR_EN && !hit));
        if (hit && wr) mem[w][idx] = d;
    endtask

    // Idle cycles with inputs that must be ignored outside a setup phase.
    task automatic idle(input int w, input int n);
        obs_t o;
        for (int k = 0; k < n; k++) begin
            @(negedge pclk);
            o = sample(w);
            chk("idle_pready", 32'(o.pready), 32'd0);
            chk("idle_wr_en",  32'(o.wr_en),  32'd0);
            chk("idle_prdata", o.prdata,      32'd0);
            if ($urandom % 2 == 0)
                drive(w, 1'b0, 1'($urandom), 1'($urandom), ADDR_W'($urandom), $urandom);
            else
                drive(w, 1'b1, 1'b1, 1'($urandom), ADDR_W'($urandom), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        int                w, r;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk_all_zero(0, "rst0");
        chk_all_zero(1, "rst1");
        rst = 1'b0;
        @(negedge pclk);
        chk_all_zero(0, "post_rst0");
        chk_all_zero(1, "post_rst1");

        xfer(1, 1'b1, 8'h04, 32'hA5A5_0001);
        idle(1, 2);
        xfer(0, 1'b1, 8'h0C, 32'h1234_5678);
        xfer(0, 1'b0, 8'h0C, $urandom);
        xfer(1, 1'b1, 8'h10, 32'h0BAD_0010);
        xfer(1, 1'b1, 8'h02, 32'h0BAD_0002);
        xfer(1, 1'b1, 8'h00, 32'h5A5A_C0DE);
        xfer(1, 1'b0, 8'h00, $urandom);
        idle(1, 1);

        // Drop psel during the wait state.
        @(negedge pclk);
        drive(1, 1'b1, 1'b0, 1'b1, 8'h08, 32'hDEAD_BEEF);
        @(negedge pclk);
        drive(1, 1'b0, 1'b0, 1'b1, 8'h08, 32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            chk("abort_wr_en",  32'(wr_en1),      32'd0);
            chk("abort_pready", 32'(bus1.pready), 32'd0);
        end
        xfer(1, 1'b0, 8'h08, $urandom);

        // Reset in the middle of an access.
        @(negedge pclk);
        drive(1, 1'b1, 1'b0, 1'b1, 8'h0C, 32'hCAFE_0003);
        @(negedge pclk);
        drive(1, 1'b1, 1'b1, 1'b1, 8'h0C, 32'hCAFE_0003);
        rst = 1'b1;
        @(negedge pclk);
        chk_all_zero(1, "mid_rst");
        rst = 1'b0;
        model_reset();
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge pclk);
        chk_all_zero(1, "after_mid_rst");
        xfer(1, 1'b0, 8'h0C, $urandom);

        for (int n = 0; n < 80; n++) begin
            w = int'($urandom % 2);
            r = int'($urandom % 8);
            if (r < 5) ra = ADDR_W'((r % 4) * 4);
            else       ra = ADDR_W'($urandom);
            xfer(w, 1'($urandom), ra, $urandom);
            if ($urandom % 2 == 0) idle(w, 1 + int'($urandom % 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
